// File: rtl/uart_pkg.sv
// Shared types and constants for the UART datapath.
// Used by the TX engine today and the RX path later.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Acceptance is judged on registered flags, never on same-cycle activity.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: byte FIFO feeding a shift-register FSM
// paced by an internal clock-enable baud counter.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 217,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     tx_wen,
    input  logic [7:0]               uart_din,
    input  logic                     ovflw_clr,
    output logic                     tx,
    output logic                     tx_full,
    output logic                     tx_empty,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic                     tx_ovflw
);

    localparam int                 IW       = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]      BIT_LAST = IW'(UART_DATA_BITS - 1);

    tx_state_t                  state;
    logic [CNT_W-1:0]           cnt;
    logic [IW-1:0]              bit_idx;
    logic [UART_DATA_BITS-1:0]  shift;
    logic                       tx_r;
    logic                       busy_r;
    logic                       ovflw_r;
    logic                       baud_done;
    logic                       fifo_pop;
    logic [7:0]                 fifo_dout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (Rst),
        .push  (tx_wen),
        .pop   (fifo_pop),
        .din   (uart_din),
        .dout  (fifo_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign baud_done = (cnt == CNT_LAST);

    // Pop when idle, or on the last stop-bit cycle to chain frames gap-free.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !tx_empty;
            STOP:    fifo_pop = baud_done && !tx_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (fifo_pop) begin
                        shift   <= fifo_dout;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        cnt   <= '0;
                        tx_r  <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            tx_r  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        cnt <= '0;
                        if (fifo_pop) begin
                            shift   <= fifo_dout;
                            bit_idx <= '0;
                            tx_r    <= 1'b0;
                            state   <= START;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (Rst) begin
            ovflw_r <= 1'b0;
        end else if (tx_wen && tx_full) begin
            ovflw_r <= 1'b1;
        end else if (ovflw_clr) begin
            ovflw_r <= 1'b0;
        end
    end

    assign tx       = tx_r;
    assign tx_busy  = busy_r;
    assign tx_ovflw = ovflw_r;

endmodule
